axis_tlast_gen_reg: RTL and testbench

//  AXI4-Stream packetiser: attaches TLAST to an unframed stream every pkt_length beats.

---
 rtl/axis_tlast_gen_reg.sv | 122 ++++++++++++
 tb/tb_axis_tlast_gen_reg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_tlast_gen_reg.sv
// AXI4-Stream packetiser with a registered 2-entry slice on the datapath.
// Each beat's TLAST is decided when the beat is accepted and travels with it,
// so downstream stalls never shift packet boundaries.
module axis_tlast_gen_reg #(
    parameter int TDATA_WIDTH    = 8,
    parameter int MAX_PKT_LENGTH = 256,
    parameter int EARLY_TERM     = 0,
    parameter int PKT_CNT_WIDTH  = 16,
    localparam int CW            = $clog2(MAX_PKT_LENGTH) + 1
) (
    input  logic                     aclk,
    input  logic                     resetn,
    input  logic [CW-1:0]            pkt_length,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [CW-1:0]            o_cnt,
    output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt,
    output logic                     o_early_term
);

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic                   last;
    } beat_t;

    localparam logic [CW-1:0] MAX_L = CW'(MAX_PKT_LENGTH);

    beat_t             main_q, skid_q, in_beat;
    logic              main_vld, skid_vld, skid_vld_nxt, tready_q;
    logic              in_hs, out_hs, pop;
    logic [CW-1:0]     cnt, len_q, len_eff, cur_len;
    logic              last_len, last_up, beat_last;

    assign in_hs  = s_axis_tvalid & tready_q;
    assign out_hs = main_vld & m_axis_tready;
    // Main register can take a new beat when empty or being drained this cycle.
    assign pop    = ~main_vld | m_axis_tready;

    // Length resolution and per-beat TLAST decision.
    always_comb begin
        len_eff   = pkt_length;
        if (pkt_length == '0 || pkt_length > MAX_L)
            len_eff = MAX_L;
        cur_len   = (cnt == '0) ? len_eff : len_q;
        last_len  = (cnt == cur_len - CW'(1));
        last_up   = (EARLY_TERM != 0) && s_axis_tlast;
        beat_last = last_len | last_up;
        in_beat   = '{data: s_axis_tdata, last: beat_last};
    end

    // Skid occupancy after this edge; ready is its registered inverse.
    always_comb begin
        skid_vld_nxt = skid_vld;
        if (pop)
            skid_vld_nxt = 1'b0;
        else if (in_hs)
            skid_vld_nxt = 1'b1;
    end

    // Two-entry register slice: main feeds the output, skid absorbs one stalled beat.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            if (pop) begin
                if (skid_vld) begin
                    main_q   <= skid_q;
                    main_vld <= 1'b1;
                end else begin
                    main_vld <= in_hs;
                    if (in_hs)
                        main_q <= in_beat;
                end
            end else if (in_hs) begin
                skid_q <= in_beat;
            end
            skid_vld <= skid_vld_nxt;
            tready_q <= ~skid_vld_nxt;
        end
    end

    // Beat counter and per-packet length latch, advanced only on accepted beats.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            len_q        <= '0;
            o_early_term <= 1'b0;
        end else begin
            o_early_term <= in_hs & last_up & ~last_len;
            if (in_hs) begin
                if (cnt == '0)
                    len_q <= len_eff;
                cnt <= beat_last ? '0 : cnt + CW'(1);
            end
        end
    end

    // Completed-packet counter, counted as packets leave the block.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn)
            o_pkt_cnt <= '0;
        else if (out_hs && main_q.last)
            o_pkt_cnt <= o_pkt_cnt + PKT_CNT_WIDTH'(1);
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = main_vld;
    assign m_axis_tdata  = main_q.data;
    assign m_axis_tlast  = main_q.last;
    assign o_cnt         = cnt;

endmodule

// File: tb/tb_axis_tlast_gen_reg.sv
// Directed bench for axis_tlast_gen_reg: two instances (early termination on/off)
// share one input stream; output beats are logged into queues and checked per test.
module tb_axis_tlast_gen_reg;

    localparam int CW = 4;  // MAX_PKT_LENGTH = 8

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic [CW-1:0] pkt_length = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_ready = 1'b0;
    logic [7:0]  s_tdata = '0;

    logic        s_tready, m_valid, m_last, early;
    logic [7:0]  m_data;
    logic [CW-1:0] cnt;
    logic [15:0] pkt_cnt;

    logic        s_tready0, m_valid0, m_last0, early0;
    logic [7:0]  m_data0;
    logic [CW-1:0] cnt0;
    logic [15:0] pkt_cnt0;

    int tests = 0, failed = 0;
    logic [8:0] q1[$], q0[$];
    logic [CW-1:0] cnt_at_hs;
    bit drv_done;

    always #5 aclk = ~aclk;

    axis_tlast_gen_reg #(.TDATA_WIDTH(8), .MAX_PKT_LENGTH(8), .EARLY_TERM(1), .PKT_CNT_WIDTH(16)) dut (
        .aclk(aclk), .resetn(resetn), .pkt_length(pkt_length),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data), .m_axis_tlast(m_last),
        .o_cnt(cnt), .o_pkt_cnt(pkt_cnt), .o_early_term(early));

    axis_tlast_gen_reg #(.TDATA_WIDTH(8), .MAX_PKT_LENGTH(8), .EARLY_TERM(0), .PKT_CNT_WIDTH(16)) dut0 (
        .aclk(aclk), .resetn(resetn), .pkt_length(pkt_length),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_valid0), .m_axis_tready(m_ready), .m_axis_tdata(m_data0), .m_axis_tlast(m_last0),
        .o_cnt(cnt0), .o_pkt_cnt(pkt_cnt0), .o_early_term(early0));

    // Output log: a beat is taken when valid and ready are both high before the edge.
    always @(negedge aclk) begin
        if (resetn) begin
            if (m_valid && m_ready)  q1.push_back({m_last, m_data});
            if (m_valid0 && m_ready) q0.push_back({m_last0, m_data0});
        end
    end

    // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic drive_beat(input logic [7:0] d, input logic l);
        int n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
        @(negedge aclk);
        while (!s_tready && n < 200) begin @(negedge aclk); n++; end
        if (!s_tready) begin
            tests++; failed++;
            $display("FAIL accept_timeout data=%0d ready stayed 0 for 200 cycles", d);
        end
        cnt_at_hs = cnt;
        @(posedge aclk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        tests++; if ({s_tready, m_valid, m_last, m_data} !== 11'd0) begin failed++;
            $display("FAIL reset_outputs got tready=%b tvalid=%b tlast=%b data=%0h want all 0", s_tready, m_valid, m_last, m_data); end
        tests++; if ({cnt, pkt_cnt, early} !== 21'd0) begin failed++;
            $display("FAIL reset_counters got cnt=%0d pkt=%0d early=%b want 0", cnt, pkt_cnt, early); end
        @(negedge aclk); resetn = 1'b1; #1;
        tests++; if (s_tready !== 1'b0) begin failed++;
            $display("FAIL tready_before_edge got %b want 0", s_tready); end
        @(posedge aclk); #1;
        tests++; if (s_tready !== 1'b1) begin failed++;
            $display("FAIL tready_after_release got %b want 1", s_tready); end
    endtask

    task automatic test_basic;
        q1.delete(); pkt_length = 4; m_ready = 1'b1;
        tests++; if (m_valid !== 1'b0) begin failed++;
            $display("FAIL basic_idle_tvalid got %b want 0", m_valid); end
        drive_beat(8'd0, 1'b0);
        tests++; if (m_valid !== 1'b1 || m_data !== 8'd0) begin failed++;
            $display("FAIL basic_latency got tvalid=%b data=%0d want 1,0", m_valid, m_data); end
        for (int i = 1; i < 8; i++) drive_beat(8'(i), 1'b0);
        drain(4);
        tests++; if (q1.size() != 8) begin failed++;
            $display("FAIL basic_count got %0d want 8", q1.size()); end
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= q1.size() || q1[i] !== {(i % 4 == 3), 8'(i)}) begin failed++;
                $display("FAIL basic_beat%0d got %h want %h", i, (i < q1.size()) ? q1[i] : 9'h1ff, {(i % 4 == 3), 8'(i)}); end
        end
        tests++; if (pkt_cnt !== 16'd2) begin failed++;
            $display("FAIL basic_pkt_cnt got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_backpressure;
        logic pv;
        logic [8:0] pd;
        q1.delete(); pkt_length = 4; drv_done = 1'b0; pv = 1'b0; pd = '0;
        fork
            begin
                for (int i = 0; i < 64; i++) drive_beat(8'(i), 1'b0);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(negedge aclk);
                    if (pv) begin
                        tests++;
                        if (m_valid !== 1'b1 || {m_last, m_data} !== pd) begin failed++;
                            $display("FAIL stall_hold got tvalid=%b beat=%h want 1,%h", m_valid, {m_last, m_data}, pd); end
                    end
                    if (!s_tready) begin
                        tests++;
                        if (m_valid !== 1'b1 || pv !== 1'b1) begin failed++;
                            $display("FAIL tready_low_not_full got tvalid=%b stalled=%b want 1,1", m_valid, pv); end
                    end
                    pv = m_valid & ~m_ready; pd = {m_last, m_data};
                    @(posedge aclk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain(6);
        tests++; if (q1.size() != 64) begin failed++;
            $display("FAIL bp_count got %0d want 64", q1.size()); end
        for (int i = 0; i < 64; i++) begin
            tests++;
            if (i >= q1.size() || q1[i] !== {(i % 4 == 3), 8'(i)}) begin failed++;
                $display("FAIL bp_beat%0d got %h want %h", i, (i < q1.size()) ? q1[i] : 9'h1ff, {(i % 4 == 3), 8'(i)}); end
        end
        tests++; if (pkt_cnt !== 16'd18) begin failed++;
            $display("FAIL bp_pkt_cnt got %0d want 18", pkt_cnt); end
    endtask

    task automatic test_len_change;
        logic [CW-1:0] exp_cnt [8] = '{0, 1, 2, 3, 0, 1, 0, 1};
        logic [7:0] exp_last = 8'b1010_1000;  // bit i = tlast on beat i
        q1.delete(); pkt_length = 4; m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) pkt_length = 2;
            drive_beat(8'(8'h20 + i), 1'b0);
            tests++;
            if (cnt_at_hs !== exp_cnt[i]) begin failed++;
                $display("FAIL lenchg_cnt%0d got %0d want %0d", i, cnt_at_hs, exp_cnt[i]); end
        end
        drain(4);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (i >= q1.size() || q1[i] !== {exp_last[i], 8'(8'h20 + i)}) begin failed++;
                $display("FAIL lenchg_beat%0d got %h want %h", i, (i < q1.size()) ? q1[i] : 9'h1ff, {exp_last[i], 8'(8'h20 + i)}); end
        end
    endtask

    task automatic test_len_bounds;
        logic [CW-1:0] lens [3] = '{4'd0, 4'd12, 4'd1};
        int nb [3] = '{16, 16, 4};
        for (int t = 0; t < 3; t++) begin
            q1.delete(); pkt_length = lens[t]; m_ready = 1'b1;
            for (int i = 0; i < nb[t]; i++) drive_beat(8'(i), 1'b0);
            drain(4);
            tests++; if (q1.size() != nb[t]) begin failed++;
                $display("FAIL bounds_len%0d_count got %0d want %0d", lens[t], q1.size(), nb[t]); end
            for (int i = 0; i < nb[t]; i++) begin
                logic el;
                el = (lens[t] == 4'd1) ? 1'b1 : (i % 8 == 7);
                tests++;
                if (i >= q1.size() || q1[i] !== {el, 8'(i)}) begin failed++;
                    $display("FAIL bounds_len%0d_beat%0d got %h want %h", lens[t], i, (i < q1.size()) ? q1[i] : 9'h1ff, {el, 8'(i)}); end
            end
        end
        tests++; if (pkt_cnt !== 16'd29) begin failed++;
            $display("FAIL bounds_pkt_cnt got %0d want 29", pkt_cnt); end
    endtask

    task automatic test_early_term;
        q1.delete(); q0.delete(); pkt_length = 6; m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive_beat(8'(8'h40 + i), (i == 2));
            tests++;
            if (early !== (i == 2) || early0 !== 1'b0) begin failed++;
                $display("FAIL early_pulse_beat%0d got et1=%b et0=%b want %b,0", i, early, early0, (i == 2)); end
        end
        drain(4);
        tests++; if (early !== 1'b0) begin failed++;
            $display("FAIL early_pulse_idle got %b want 0", early); end
        for (int i = 0; i < 9; i++) begin
            tests++;
            if (i >= q1.size() || q1[i] !== {(i == 2 || i == 8), 8'(8'h40 + i)}) begin failed++;
                $display("FAIL et1_beat%0d got %h want %h", i, (i < q1.size()) ? q1[i] : 9'h1ff, {(i == 2 || i == 8), 8'(8'h40 + i)}); end
            tests++;
            if (i >= q0.size() || q0[i] !== {(i == 5), 8'(8'h40 + i)}) begin failed++;
                $display("FAIL et0_beat%0d got %h want %h", i, (i < q0.size()) ? q0[i] : 9'h1ff, {(i == 5), 8'(8'h40 + i)}); end
        end
        tests++; if (pkt_cnt !== 16'd31 || pkt_cnt0 !== 16'd30) begin failed++;
            $display("FAIL et_pkt_cnt got et1=%0d et0=%0d want 31,30", pkt_cnt, pkt_cnt0); end
    endtask

    task automatic test_reset_mid;
        pkt_length = 5; m_ready = 1'b1;
        drive_beat(8'h60, 1'b0);
        drive_beat(8'h61, 1'b0);
        m_ready = 1'b0;
        drive_beat(8'h62, 1'b0);
        #2 resetn = 1'b0; #1;
        tests++; if ({s_tready, m_valid, m_last, m_data, cnt, pkt_cnt, early} !== '0) begin failed++;
            $display("FAIL midreset_outputs got tready=%b tvalid=%b tlast=%b data=%0h cnt=%0d pkt=%0d want all 0",
                     s_tready, m_valid, m_last, m_data, cnt, pkt_cnt); end
        @(negedge aclk); @(negedge aclk); resetn = 1'b1;
        @(posedge aclk); #1;
        q1.delete(); m_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_beat(8'(8'h70 + i), 1'b0);
        drain(4);
        tests++; if (q1.size() != 5) begin failed++;
            $display("FAIL midreset_count got %0d want 5", q1.size()); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (i >= q1.size() || q1[i] !== {(i == 4), 8'(8'h70 + i)}) begin failed++;
                $display("FAIL midreset_beat%0d got %h want %h", i, (i < q1.size()) ? q1[i] : 9'h1ff, {(i == 4), 8'(8'h70 + i)}); end
        end
        tests++; if (pkt_cnt !== 16'd1) begin failed++;
            $display("FAIL midreset_pkt_cnt got %0d want 1", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len_change();
        test_len_bounds();
        test_early_term();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
